// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - CDB request/grant and broadcast bus bundle
interface cdb_arbiter_if #(
   parameter int NUM_ISR        = 4,
   parameter int DATA_WIDTH     = 32,
   parameter int ROB_ENTRY_LOG2 = 2
);
   logic [NUM_ISR-1:0]                isr_request;
   logic [NUM_ISR*DATA_WIDTH-1:0]     isr_data;
   logic [NUM_ISR*ROB_ENTRY_LOG2-1:0] isr_id;
   logic [NUM_ISR-1:0]                isr_grant;
   logic                              flush;
   logic                              cdb_valid;
   logic [DATA_WIDTH-1:0]             cdb_data;
   logic [ROB_ENTRY_LOG2-1:0]         cdb_id;

   modport master (
      output isr_request, isr_data, isr_id, flush,
      input  isr_grant, cdb_valid, cdb_data, cdb_id
   );

   modport slave (
      input  isr_request, isr_data, isr_id, flush,
      output isr_grant, cdb_valid, cdb_data, cdb_id
   );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin CDB arbiter with registered result broadcast
module cdb_arbiter #(
   parameter int NUM_ISR        = 4,
   parameter int DATA_WIDTH     = 32,
   parameter int ROB_ENTRY      = 4,
   parameter int ROB_ENTRY_LOG2 = $clog2(ROB_ENTRY),
   parameter int PTR_W          = $clog2(NUM_ISR)
) (
   input  logic         CLK,
   input  logic         RSTN,
   cdb_arbiter_if.slave bus
);
   logic [PTR_W-1:0]          rr_ptr;
   logic [PTR_W-1:0]          win_idx;
   logic [PTR_W-1:0]          next_ptr;
   logic [NUM_ISR-1:0]        req_eff;
   logic [NUM_ISR-1:0]        grant;
   logic                      found;
   logic [DATA_WIDTH-1:0]     win_data;
   logic [ROB_ENTRY_LOG2-1:0] win_id;

   // Pass 0 covers issuers at or above rr_ptr, pass 1 the wrapped-around ones below it.
   always_comb begin
      grant    = '0;
      found    = 1'b0;
      win_idx  = '0;
      win_data = '0;
      win_id   = '0;
      req_eff  = bus.flush ? '0 : bus.isr_request;
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < NUM_ISR; i++) begin
            if (!found && req_eff[i] && ((pass == 0) == (PTR_W'(i) >= rr_ptr))) begin
               found    = 1'b1;
               grant[i] = 1'b1;
               win_idx  = PTR_W'(i);
               win_data = bus.isr_data[i*DATA_WIDTH +: DATA_WIDTH];
               win_id   = bus.isr_id[i*ROB_ENTRY_LOG2 +: ROB_ENTRY_LOG2];
            end
         end
      end
   end

   assign next_ptr      = (win_idx == PTR_W'(NUM_ISR-1)) ? '0 : win_idx + 1'b1;
   assign bus.isr_grant = grant;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         rr_ptr        <= '0;
         bus.cdb_valid <= 1'b0;
         bus.cdb_data  <= '0;
         bus.cdb_id    <= '0;
      end else begin
         bus.cdb_valid <= found;
         if (found) begin
            rr_ptr       <= next_ptr;
            bus.cdb_data <= win_data;
            bus.cdb_id   <= win_id;
         end
      end
   end

   a_grant_onehot: assert property (@(posedge CLK) disable iff (!RSTN)
      $onehot0(bus.isr_grant));
   a_grant_has_req: assert property (@(posedge CLK) disable iff (!RSTN)
      (bus.isr_grant & ~bus.isr_request) == '0);
   // Issuers may drop requests only once granted, or on flush.
   a_req_stable: assert property (@(posedge CLK) disable iff (!RSTN)
      !bus.flush |=> ((($past(bus.isr_request) & ~$past(bus.isr_grant)) & ~bus.isr_request) == '0));
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter (4 and 3 issuers)
module tb_cdb_arbiter;
   logic CLK;
   logic RSTN;

   cdb_arbiter_if #(.NUM_ISR(4), .DATA_WIDTH(32), .ROB_ENTRY_LOG2(2)) bus4 ();
   cdb_arbiter_if #(.NUM_ISR(3), .DATA_WIDTH(32), .ROB_ENTRY_LOG2(2)) bus3 ();

   cdb_arbiter #(.NUM_ISR(4), .DATA_WIDTH(32), .ROB_ENTRY(4)) dut4 (
      .CLK(CLK), .RSTN(RSTN), .bus(bus4.slave));
   cdb_arbiter #(.NUM_ISR(3), .DATA_WIDTH(32), .ROB_ENTRY(4)) dut3 (
      .CLK(CLK), .RSTN(RSTN), .bus(bus3.slave));

   typedef struct {
      logic        v;
      logic [31:0] d;
      logic [1:0]  id;
   } bcast_t;

   bcast_t      exp_q[$];
   logic [31:0] dat [4];
   logic [1:0]  ids [4];
   int          m_ptr;
   logic [31:0] m_data;
   logic [1:0]  m_id;
   logic [3:0]  act_grant;
   int          checks;
   int          errors;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic int model_winner(input logic [3:0] req, input int ptr, input logic fl);
      int k;
      if (fl) return -1;
      k = ptr;
      repeat (4) begin
         if (req[k]) return k;
         k = (k == 3) ? 0 : k + 1;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_ptr  = 0;
      m_data = '0;
      m_id   = '0;
      exp_q.delete();
   endtask

   // Drives one cycle on the 4-issuer bus and queues the broadcast it should cause.
   task automatic drive(input logic [3:0] req, input logic fl);
      int w;
      @(negedge CLK);
      bus4.isr_request = req;
      bus4.flush       = fl;
      #1;
      act_grant = bus4.isr_grant;
      w = model_winner(req, m_ptr, fl);
      if (w >= 0) begin
         m_data = dat[w];
         m_id   = ids[w];
         m_ptr  = (w + 1) % 4;
         exp_q.push_back('{1'b1, m_data, m_id});
      end else begin
         exp_q.push_back('{1'b0, m_data, m_id});
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RSTN = 1'b0;
      bus4.isr_request = 4'b1111;
      #2;
      checks++; if (bus4.cdb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus4.cdb_valid); end
      checks++; if (bus4.cdb_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", bus4.cdb_data); end
      checks++; if (bus4.cdb_id !== 2'd0) begin errors++; $display("FAIL reset_id got %0d want 0", bus4.cdb_id); end
      checks++; if (bus4.isr_grant !== 4'b0001) begin errors++; $display("FAIL reset_grant got %b want 0001", bus4.isr_grant); end
      @(negedge CLK);
      bus4.isr_request = 4'b0000;
      RSTN = 1'b1;
      model_reset();
   endtask

   task automatic test_single();
      bcast_t e;
      drive(4'b0100, 1'b0);
      checks++; if (act_grant !== 4'b0100) begin errors++; $display("FAIL single_grant got %b want 0100", act_grant); end
      checks++; if (bus4.cdb_valid !== 1'b1 || bus4.cdb_data !== 32'hDEADBEEF || bus4.cdb_id !== 2'd3) begin
         errors++; $display("FAIL single_bcast got %b/%h/%0d want 1/deadbeef/3", bus4.cdb_valid, bus4.cdb_data, bus4.cdb_id);
      end
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL single_sb queue empty"); end
      else begin
         e = exp_q.pop_front();
         if (bus4.cdb_valid !== e.v || bus4.cdb_data !== e.d || bus4.cdb_id !== e.id) begin
            errors++; $display("FAIL single_sb got %b/%h/%0d want %b/%h/%0d", bus4.cdb_valid, bus4.cdb_data, bus4.cdb_id, e.v, e.d, e.id);
         end
      end
   endtask

   task automatic run_table(input string name, input logic [3:0] reqs[], input logic fls[], input logic [3:0] gnts[]);
      bcast_t e;
      for (int n = 0; n < reqs.size(); n++) begin
         drive(reqs[n], fls[n]);
         checks++;
         if (act_grant !== gnts[n]) begin
            errors++; $display("FAIL %s_grant step %0d got %b want %b", name, n, act_grant, gnts[n]);
         end
         checks++;
         if (exp_q.size() == 0) begin errors++; $display("FAIL %s_sb step %0d queue empty", name, n); end
         else begin
            e = exp_q.pop_front();
            if (bus4.cdb_valid !== e.v || bus4.cdb_data !== e.d || bus4.cdb_id !== e.id) begin
               errors++;
               $display("FAIL %s_sb step %0d got %b/%h/%0d want %b/%h/%0d", name, n,
                        bus4.cdb_valid, bus4.cdb_data, bus4.cdb_id, e.v, e.d, e.id);
            end
         end
      end
   endtask

   task automatic test_wrap();
      run_table("wrap", '{4'b0011, 4'b0010}, '{1'b0, 1'b0}, '{4'b0001, 4'b0010});
   endtask

   task automatic test_flush();
      run_table("flush", '{4'b1010, 4'b1010, 4'b1010, 4'b0010, 4'b0000},
                '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
                '{4'b0000, 4'b0000, 4'b1000, 4'b0010, 4'b0000});
   endtask

   task automatic test_reset_mid();
      run_table("premid", '{4'b0010}, '{1'b0}, '{4'b0010});
      #1 RSTN = 1'b0;
      #1;
      checks++; if (bus4.cdb_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", bus4.cdb_valid); end
      checks++; if (bus4.cdb_data !== 32'h0) begin errors++; $display("FAIL mid_data got %h want 0", bus4.cdb_data); end
      bus4.isr_request = 4'b1111;
      model_reset();
      #1 RSTN = 1'b1;
      run_table("postmid", '{4'b1111}, '{1'b0}, '{4'b0001});
   endtask

   task automatic test_back_to_back();
      #1 RSTN = 1'b0;
      #1 RSTN = 1'b1;
      model_reset();
      run_table("b2b", '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0000},
                '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
                '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000, 4'b0000});
   endtask

   task automatic test_nonpow2();
      logic [2:0] gnts [5] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
      logic [1:0] id_q[$];
      logic [1:0] eid;
      for (int n = 0; n < 5; n++) begin
         @(negedge CLK);
         bus3.isr_request = 3'b111;
         bus3.flush       = 1'b0;
         #1;
         checks++;
         if (bus3.isr_grant !== gnts[n]) begin
            errors++; $display("FAIL np2_grant step %0d got %b want %b", n, bus3.isr_grant, gnts[n]);
         end
         for (int k = 0; k < 3; k++) if (gnts[n][k]) id_q.push_back(2'(k));
         @(posedge CLK);
         #1;
         checks++;
         if (id_q.size() == 0) begin errors++; $display("FAIL np2_sb step %0d queue empty", n); end
         else begin
            eid = id_q.pop_front();
            if (bus3.cdb_valid !== 1'b1 || bus3.cdb_id !== eid) begin
               errors++; $display("FAIL np2_sb step %0d got %b/%0d want 1/%0d", n, bus3.cdb_valid, bus3.cdb_id, eid);
            end
         end
      end
      @(negedge CLK);
      bus3.flush = 1'b1;
      @(negedge CLK);
      bus3.flush       = 1'b0;
      bus3.isr_request = 3'b000;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int k = 0; k < 4; k++) begin
         dat[k] = 32'hA000_0000 + 32'(k);
         ids[k] = 2'((k + 1) % 4);
      end
      dat[2] = 32'hDEADBEEF;
      for (int k = 0; k < 4; k++) begin
         bus4.isr_data[k*32 +: 32] = dat[k];
         bus4.isr_id[k*2 +: 2]     = ids[k];
      end
      bus4.flush = 1'b0;
      for (int k = 0; k < 3; k++) begin
         bus3.isr_data[k*32 +: 32] = 32'h3000_0000 + 32'(k);
         bus3.isr_id[k*2 +: 2]     = 2'(k);
      end
      bus3.isr_request = 3'b000;
      bus3.flush       = 1'b0;
      model_reset();

      test_reset();
      test_single();
      test_wrap();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      test_nonpow2();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
